wb_mem_tester: RTL and testbench

- Wishbone classic master that fills a word-addressed memory region with a deterministic pattern, then reads it back and checks every word.
- Drives any Wishbone slave, typically the team's block-RAM slave, for memory-controller bring-up and regression.
- Reports completion, mismatch count, first failing address, and bus errors or timeouts to a status/host side.

---
 rtl/wb_mem_tester_pkg.sv | 21 ++
 rtl/wb_xfer_timer.sv | 29 ++
 rtl/wb_mem_tester.sv | 193 +++++++++++++++++++
 tb/tb_wb_mem_tester.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_tester_pkg.sv
// Shared types and helpers for the Wishbone memory tester: FSM states,
// bus constants and the fill/check pattern generator.
package wb_mem_tester_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [3:0] SEL_ALL        = 4'hF;
    localparam int         BYTES_PER_WORD = 4;

    // Seed mixed with the word index in both halves so that neighbouring
    // words and address-aliasing faults produce distinct data.
    function automatic logic [31:0] pattern(input logic [31:0] idx, input logic [31:0] seed);
        return seed ^ idx ^ {idx[15:0], 16'h0000};
    endfunction

endpackage

// File: rtl/wb_xfer_timer.sv
// Loadable down-counter guarding a single Wishbone transfer; expired_o marks
// the last permitted wait cycle.
module wb_xfer_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // A load value of zero never reaches one, so the timer stays silent.
    assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/wb_mem_tester.sv
// Wishbone classic master: writes a seeded pattern over a word region, reads
// it back, counts mismatches and reports bus errors/timeouts.
module wb_mem_tester
    import wb_mem_tester_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          ADR_W   = 32,
    parameter int          CNT_W   = 11,
    parameter logic [31:0] SEED    = 32'hA5A5_0000,
    parameter int          TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADR_W-1:0]  base_adr,
    input  logic [CNT_W-1:0]  nwords,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              abort,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADR_W-1:0]  fail_adr,
    output logic [ADR_W-1:0]  wb_adr,
    output logic [DATA_W-1:0] wb_dat_ms,
    input  logic [DATA_W-1:0] wb_dat_sm,
    output logic [3:0]        wb_sel,
    output logic              wb_we,
    output logic              wb_stb,
    output logic              wb_cyc,
    input  logic              wb_ack,
    input  logic              wb_err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t             state_q;
    logic [ADR_W-1:0]   base_q;
    logic [CNT_W-1:0]   nwords_q;
    logic [CNT_W-1:0]   idx_q;
    logic               stb_q;
    logic               we_q;
    logic [ADR_W-1:0]   adr_q;
    logic [DATA_W-1:0]  dat_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic               abort_q;
    logic [CNT_W-1:0]   err_count_q;
    logic [ADR_W-1:0]   fail_adr_q;

    logic [ADR_W-1:0]   base_aligned;
    logic [CNT_W-1:0]   last_idx;
    logic [CNT_W-1:0]   idx_d;
    logic [ADR_W-1:0]   adr_d;
    logic [CNT_W-1:0]   err_count_d;
    logic               mismatch;
    logic               tmr_expired;
    logic               timeout_hit;
    logic               xfer_fault;

    assign base_aligned = base_adr & ~ADR_W'(3);
    assign last_idx     = nwords_q - CNT_W'(1);
    assign idx_d        = idx_q + CNT_W'(1);
    assign adr_d        = adr_q + ADR_W'(BYTES_PER_WORD);
    assign mismatch     = (wb_dat_sm != pattern(32'(idx_q), SEED));

    always_comb begin
        err_count_d = err_count_q;
        if ((state_q == READ) && stb_q && wb_ack && !wb_err && mismatch && !(&err_count_q)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    // Reloaded whenever no transfer is pending or one completes, so each
    // presentation of stb starts from a full budget.
    wb_xfer_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (!stb_q || wb_ack || wb_err),
        .dec_i      (stb_q),
        .load_val_i (TW'(TIMEOUT)),
        .expired_o  (tmr_expired)
    );

    assign timeout_hit = (TIMEOUT != 0) && tmr_expired && !wb_ack;
    assign xfer_fault  = stb_q && (wb_err || timeout_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            nwords_q    <= '0;
            idx_q       <= '0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            abort_q     <= 1'b0;
            err_count_q <= '0;
            fail_adr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q      <= base_aligned;
                        nwords_q    <= nwords;
                        idx_q       <= '0;
                        err_count_q <= '0;
                        abort_q     <= 1'b0;
                        fail_adr_q  <= '0;
                        pass_q      <= 1'b0;
                        if (nwords == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= WRITE;
                            busy_q  <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= 1'b1;
                            adr_q   <= base_aligned;
                            dat_q   <= pattern(32'd0, SEED);
                        end
                    end
                end
                WRITE, READ: begin
                    if (!stb_q) begin
                        // Single idle cycle after the write phase; launch word 0 read.
                        stb_q <= 1'b1;
                        we_q  <= 1'b0;
                        adr_q <= base_q;
                        idx_q <= '0;
                    end else if (xfer_fault) begin
                        stb_q      <= 1'b0;
                        we_q       <= 1'b0;
                        abort_q    <= 1'b1;
                        fail_adr_q <= adr_q;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= FIN;
                    end else if (wb_ack) begin
                        if (state_q == READ) begin
                            err_count_q <= err_count_d;
                            if (mismatch && (err_count_q == '0)) begin
                                fail_adr_q <= adr_q;
                            end
                        end
                        if (idx_q == last_idx) begin
                            stb_q <= 1'b0;
                            we_q  <= 1'b0;
                            idx_q <= '0;
                            if (state_q == WRITE) begin
                                state_q <= READ;
                            end else begin
                                state_q <= FIN;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                pass_q  <= (err_count_d == '0);
                            end
                        end else begin
                            idx_q <= idx_d;
                            adr_q <= adr_d;
                            if (state_q == WRITE) begin
                                dat_q <= pattern(32'(idx_d), SEED);
                            end
                        end
                    end
                end
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign abort     = abort_q;
    assign err_count = err_count_q;
    assign fail_adr  = fail_adr_q;
    assign wb_adr    = adr_q;
    assign wb_dat_ms = dat_q;
    assign wb_sel    = stb_q ? SEL_ALL : 4'h0;
    assign wb_we     = we_q;
    assign wb_stb    = stb_q;
    assign wb_cyc    = stb_q;

endmodule

// File: tb/tb_wb_mem_tester.sv
// Directed bench for wb_mem_tester with a configurable BRAM-like slave model.
module tb_wb_mem_tester;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_adr = '0;
    logic [10:0] nwords = '0;
    logic        busy, done, pass, abort;
    logic [10:0] err_count;
    logic [31:0] fail_adr, wb_adr, wb_dat_ms;
    logic [31:0] wb_dat_sm;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_stb, wb_cyc;
    logic        wb_ack, wb_err;

    int vec_n = 0;
    int miss_n = 0;
    int cyc_n = 0;

    // slave knobs
    int          sl_max_ws = 0;
    int          sl_ws_cur;
    int          wcnt;
    bit          sl_corrupt = 0;
    bit          sl_err_en = 0;
    logic [31:0] sl_err_adr = '0;
    bit          sl_never = 0;
    logic [31:0] mem [0:2047];

    // transfer log
    logic [31:0] t_adr[$];
    logic [31:0] t_dat[$];
    logic        t_we[$];
    int          t_cyc[$];
    int          stb_hi_cnt = 0;
    int          stab_viol = 0;
    int          done_n = 0;
    bit          rd_seen = 0;
    logic        p_stb = 0, p_ack = 0, p_err = 0, p_we = 0;
    logic [31:0] p_adr = '0, p_dat = '0;
    int          start_cyc = 0;

    wb_mem_tester #(
        .DATA_W(32), .ADR_W(32), .CNT_W(11), .SEED(32'hA5A5_0000), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .nwords(nwords),
        .busy(busy), .done(done), .pass(pass), .abort(abort),
        .err_count(err_count), .fail_adr(fail_adr),
        .wb_adr(wb_adr), .wb_dat_ms(wb_dat_ms), .wb_dat_sm(wb_dat_sm),
        .wb_sel(wb_sel), .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc),
        .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] pat(input int i);
        return 32'hA5A5_0000 ^ 32'(i) ^ (32'(i) << 16);
    endfunction

    // slave: registered ack/err after the programmed number of wait states
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack <= 1'b0; wb_err <= 1'b0; wcnt <= 0; sl_ws_cur <= 0; wb_dat_sm <= '0;
        end else begin
            wb_ack <= 1'b0; wb_err <= 1'b0;
            if (wb_stb && !wb_ack && !wb_err && !sl_never) begin
                if (wcnt >= sl_ws_cur) begin
                    wcnt <= 0;
                    sl_ws_cur <= (sl_max_ws == 0) ? 0 : int'($urandom_range(sl_max_ws, 1));
                    if (sl_err_en && wb_we && (wb_adr == sl_err_adr)) begin
                        wb_err <= 1'b1;
                    end else begin
                        wb_ack <= 1'b1;
                        if (wb_we) mem[wb_adr[12:2]] <= wb_dat_ms;
                        else if (sl_corrupt && (wb_adr[12:2] == 11'd5 || wb_adr[12:2] == 11'd9))
                            wb_dat_sm <= mem[wb_adr[12:2]] ^ 32'h1;
                        else wb_dat_sm <= mem[wb_adr[12:2]];
                    end
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    // bus monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_stb) stb_hi_cnt++;
            if (done) done_n++;
            if (wb_stb && (wb_ack || wb_err)) begin
                t_adr.push_back(wb_adr); t_dat.push_back(wb_dat_ms);
                t_we.push_back(wb_we);   t_cyc.push_back(cyc_n);
                if (!wb_we) rd_seen = 1;
            end
            if (p_stb && !p_ack && !p_err && wb_stb &&
                ({wb_adr, wb_dat_ms, wb_we} !== {p_adr, p_dat, p_we})) stab_viol++;
        end
        p_stb = wb_stb; p_ack = wb_ack; p_err = wb_err;
        p_adr = wb_adr; p_dat = wb_dat_ms; p_we = wb_we;
    end

    task automatic clear_log();
        t_adr.delete(); t_dat.delete(); t_we.delete(); t_cyc.delete();
        stb_hi_cnt = 0; stab_viol = 0; rd_seen = 0;
    endtask

    task automatic run_start(input logic [31:0] b, input logic [10:0] n);
        @(negedge clk);
        base_adr = b; nwords = n; start = 1'b1; start_cyc = cyc_n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int at_cyc);
        ok = 0; at_cyc = 0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin ok = 1; at_cyc = cyc_n; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vec_n++;
        if ({busy, done, pass, abort, wb_we, wb_stb, wb_cyc} !== 7'b0) begin
            miss_n++; $display("FAIL reset_flags: got %b expected 0000000", {busy, done, pass, abort, wb_we, wb_stb, wb_cyc});
        end
        vec_n++;
        if ({err_count, fail_adr, wb_adr, wb_dat_ms, wb_sel} !== '0) begin
            miss_n++; $display("FAIL reset_regs: err_count=%h fail_adr=%h adr=%h dat=%h sel=%h expected all 0", err_count, fail_adr, wb_adr, wb_dat_ms, wb_sel);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        bit ok; int dc; int lat;
        sl_max_ws = 0; clear_log();
        run_start(32'h100, 11'd16);
        wait_done(200, ok, dc);
        vec_n++;
        if (!ok) begin miss_n++; $display("FAIL zw_done: got no done expected done within 200 cycles"); end
        lat = dc - start_cyc;
        vec_n++;
        if (lat < 65 || lat > 67) begin miss_n++; $display("FAIL zw_latency: got %0d expected 66 +/-1", lat); end
        vec_n++;
        if ({pass, abort, err_count, busy} !== {1'b1, 1'b0, 11'd0, 1'b0}) begin
            miss_n++; $display("FAIL zw_status: pass=%b abort=%b err_count=%0d busy=%b expected 1 0 0 0", pass, abort, err_count, busy);
        end
        @(negedge clk);
        vec_n++;
        if (t_adr.size() != 32) begin miss_n++; $display("FAIL zw_count: got %0d expected 32", t_adr.size()); end
        for (int i = 0; i < t_adr.size(); i++) begin
            vec_n++;
            if ({t_adr[i], t_we[i]} !== {32'h100 + 32'(4 * (i % 16)), (i < 16)}) begin
                miss_n++; $display("FAIL zw_xfer%0d: got adr=%h we=%b expected adr=%h we=%b", i, t_adr[i], t_we[i], 32'h100 + 32'(4 * (i % 16)), (i < 16));
            end
            if (i < 16) begin
                vec_n++;
                if (t_dat[i] !== pat(i)) begin miss_n++; $display("FAIL zw_wdat%0d: got %h expected %h", i, t_dat[i], pat(i)); end
            end
        end
        if (t_adr.size() >= 17) begin
            vec_n++;
            if ({t_dat[0], t_dat[15]} !== {32'hA5A5_0000, 32'hA5AA_000F}) begin
                miss_n++; $display("FAIL zw_pattern: got %h %h expected a5a50000 a5aa000f", t_dat[0], t_dat[15]);
            end
            vec_n++;
            if (t_cyc[16] - t_cyc[15] != 3) begin miss_n++; $display("FAIL zw_gap: got %0d expected 3", t_cyc[16] - t_cyc[15]); end
            vec_n++;
            if (t_cyc[1] - t_cyc[0] != 2) begin miss_n++; $display("FAIL zw_b2b: got %0d expected 2", t_cyc[1] - t_cyc[0]); end
        end
        repeat (3) @(negedge clk);
        vec_n++;
        if ({pass, done, busy} !== 3'b100) begin miss_n++; $display("FAIL zw_hold: got %b expected 100", {pass, done, busy}); end
    endtask

    task automatic test_corrupt();
        bit ok; int dc;
        sl_corrupt = 1; clear_log();
        run_start(32'h0, 11'd12);
        wait_done(200, ok, dc);
        vec_n++;
        if (!ok) begin miss_n++; $display("FAIL cor_done: got no done expected done"); end
        vec_n++;
        if ({err_count, fail_adr, pass, abort} !== {11'd2, 32'h14, 1'b0, 1'b0}) begin
            miss_n++; $display("FAIL cor_status: err_count=%0d fail_adr=%h pass=%b abort=%b expected 2 00000014 0 0", err_count, fail_adr, pass, abort);
        end
        sl_corrupt = 0;
        @(negedge clk);
    endtask

    task automatic test_zero_words();
        bit ok; int dc;
        clear_log();
        run_start(32'h500, 11'd0);
        wait_done(5, ok, dc);
        vec_n++;
        if (!ok || (dc - start_cyc) > 2) begin miss_n++; $display("FAIL nz_done: got ok=%b latency=%0d expected done within 2", ok, dc - start_cyc); end
        vec_n++;
        if ({pass, abort, err_count, fail_adr} !== {1'b1, 1'b0, 11'd0, 32'd0}) begin
            miss_n++; $display("FAIL nz_status: pass=%b abort=%b err_count=%0d fail_adr=%h expected 1 0 0 0", pass, abort, err_count, fail_adr);
        end
        repeat (2) @(negedge clk);
        vec_n++;
        if (stb_hi_cnt != 0) begin miss_n++; $display("FAIL nz_stb: got %0d stb cycles expected 0", stb_hi_cnt); end
    endtask

    task automatic test_wait_states();
        bit ok; int dc;
        sl_max_ws = 3; clear_log();
        run_start(32'h200, 11'd8);
        wait_done(400, ok, dc);
        vec_n++;
        if (!ok || !pass) begin miss_n++; $display("FAIL ws_done: got ok=%b pass=%b expected 1 1", ok, pass); end
        @(negedge clk);
        vec_n++;
        if (stab_viol != 0) begin miss_n++; $display("FAIL ws_stable: got %0d changes expected 0", stab_viol); end
        vec_n++;
        if (t_adr.size() != 16) begin miss_n++; $display("FAIL ws_count: got %0d expected 16", t_adr.size()); end
        for (int i = 0; i < t_adr.size(); i++) begin
            vec_n++;
            if ({t_adr[i], t_we[i]} !== {32'h200 + 32'(4 * (i % 8)), (i < 8)}) begin
                miss_n++; $display("FAIL ws_xfer%0d: got adr=%h we=%b expected adr=%h we=%b", i, t_adr[i], t_we[i], 32'h200 + 32'(4 * (i % 8)), (i < 8));
            end
        end
        sl_max_ws = 0;
    endtask

    task automatic test_bus_err();
        bit ok; int dc;
        sl_err_en = 1; sl_err_adr = 32'h4C; clear_log();
        run_start(32'h40, 11'd8);
        wait_done(100, ok, dc);
        vec_n++;
        if (!ok) begin miss_n++; $display("FAIL be_done: got no done expected done"); end
        vec_n++;
        if (wb_stb !== 1'b0) begin miss_n++; $display("FAIL be_stb: got %b expected 0", wb_stb); end
        vec_n++;
        if ({abort, pass, fail_adr} !== {1'b1, 1'b0, 32'h4C}) begin
            miss_n++; $display("FAIL be_status: abort=%b pass=%b fail_adr=%h expected 1 0 0000004c", abort, pass, fail_adr);
        end
        repeat (3) @(negedge clk);
        vec_n++;
        if ({rd_seen, stb_hi_cnt > 0 ? 1'b0 : 1'b1, 32'(t_adr.size())} !== {1'b0, 1'b0, 32'd4}) begin
            miss_n++; $display("FAIL be_log: read_seen=%b xfers=%0d expected 0 4", rd_seen, t_adr.size());
        end
        sl_err_en = 0;
    endtask

    task automatic test_timeout();
        bit ok; int dc;
        sl_never = 1; clear_log();
        run_start(32'h0, 11'd4);
        wait_done(50, ok, dc);
        vec_n++;
        if (!ok) begin miss_n++; $display("FAIL to_done: got no done expected done"); end
        vec_n++;
        if ({abort, pass, fail_adr} !== {1'b1, 1'b0, 32'h0}) begin
            miss_n++; $display("FAIL to_status: abort=%b pass=%b fail_adr=%h expected 1 0 0", abort, pass, fail_adr);
        end
        @(negedge clk);
        vec_n++;
        if (stb_hi_cnt < 8 || stb_hi_cnt > 9) begin miss_n++; $display("FAIL to_wait: got %0d stb cycles expected 8", stb_hi_cnt); end
        sl_never = 0;
    endtask

    task automatic test_reset_mid_run();
        bit ok; int dc; int dn;
        clear_log();
        run_start(32'h300, 11'd16);
        for (int k = 0; k < 200 && !rd_seen; k++) @(negedge clk);
        vec_n++;
        if (!rd_seen) begin miss_n++; $display("FAIL rr_read_phase: got no read expected read phase"); end
        dn = done_n;
        rst = 1'b1;
        #1;
        vec_n++;
        if ({busy, done, pass, abort, wb_stb, wb_cyc, wb_we, wb_sel, err_count, fail_adr} !== '0) begin
            miss_n++; $display("FAIL rr_outputs: busy=%b stb=%b cyc=%b sel=%h err_count=%0d expected all 0", busy, wb_stb, wb_cyc, wb_sel, err_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vec_n++;
        if (done_n != dn) begin miss_n++; $display("FAIL rr_no_done: got %0d pulses expected %0d", done_n, dn); end
        clear_log();
        run_start(32'h80, 11'd6);
        @(negedge clk);
        base_adr = 32'h400; nwords = 11'd3; start = 1'b1;
        vec_n++;
        if (busy !== 1'b1) begin miss_n++; $display("FAIL rr_busy: got %b expected 1", busy); end
        @(negedge clk);
        start = 1'b0;
        wait_done(200, ok, dc);
        vec_n++;
        if (!ok || !pass || err_count !== 11'd0) begin miss_n++; $display("FAIL rr_done: ok=%b pass=%b err_count=%0d expected 1 1 0", ok, pass, err_count); end
        @(negedge clk);
        vec_n++;
        if (t_adr.size() != 12) begin miss_n++; $display("FAIL rr_count: got %0d expected 12", t_adr.size()); end
        for (int i = 0; i < t_adr.size(); i++) begin
            vec_n++;
            if ({t_adr[i], t_we[i]} !== {32'h80 + 32'(4 * (i % 6)), (i < 6)}) begin
                miss_n++; $display("FAIL rr_xfer%0d: got adr=%h we=%b expected adr=%h we=%b", i, t_adr[i], t_we[i], 32'h80 + 32'(4 * (i % 6)), (i < 6));
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_corrupt();
        test_zero_words();
        test_wait_states();
        test_bus_err();
        test_timeout();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule
